// File: rtl/cursor_pkg.sv
// Shared types for the Buscaminas cursor controller: move directions, button
// bit positions and FSM states.
package cursor_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_LEFT,
        DIR_DOWN,
        DIR_RIGHT
    } dir_e;

    localparam int BTN_UP    = 3;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_RIGHT = 0;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_e;

    // Maps a one-hot pressed vector (bit order as on btn_n) to its direction.
    function automatic dir_e btn_to_dir(input logic [3:0] btns);
        dir_e d;
        d = DIR_NONE;
        if (btns[BTN_UP])
            d = DIR_UP;
        else if (btns[BTN_LEFT])
            d = DIR_LEFT;
        else if (btns[BTN_DOWN])
            d = DIR_DOWN;
        else if (btns[BTN_RIGHT])
            d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// One button input path: 2-flop synchroniser followed by a counter that
// accepts a level change only after DEBOUNCE_CYCLES stable cycles.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            // synchroniser -> debounce boundary
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cursor_controller.sv
// Moves the board cursor from four active-low pushbuttons with debounce,
// one move per press, hold-to-auto-repeat and wrap/clamp at the grid edges.
module cursor_controller
    import cursor_pkg::*;
#(
    parameter int COLS            = 8,
    parameter int ROWS            = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int WRAP            = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                btn_n,
    input  logic                      enable,
    output logic [$clog2(COLS)-1:0]   cur_x,
    output logic [$clog2(ROWS)-1:0]   cur_y,
    output logic                      move_pulse,
    output dir_e                      move_dir
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    logic [3:0]       pressed;
    logic             single;
    logic             same;
    state_e           state;
    logic [3:0]       held;
    logic [CNT_W-1:0] delay_cnt;
    logic             vld_p0;
    dir_e             dir_p0;
    logic [XW:0]      nx;
    logic [YW:0]      ny;

    // Returns {moved, new_x}; moved=0 when a clamped edge swallows the step.
    function automatic logic [XW:0] step_x(input logic [XW-1:0] x, input logic inc);
        logic [XW:0] r;
        if (inc) begin
            if (x == X_MAX)
                r = (WRAP != 0) ? {1'b1, {XW{1'b0}}} : {1'b0, x};
            else
                r = {1'b1, x + 1'b1};
        end else begin
            if (x == '0)
                r = (WRAP != 0) ? {1'b1, X_MAX} : {1'b0, x};
            else
                r = {1'b1, x - 1'b1};
        end
        return r;
    endfunction

    function automatic logic [YW:0] step_y(input logic [YW-1:0] y, input logic inc);
        logic [YW:0] r;
        if (inc) begin
            if (y == Y_MAX)
                r = (WRAP != 0) ? {1'b1, {YW{1'b0}}} : {1'b0, y};
            else
                r = {1'b1, y + 1'b1};
        end else begin
            if (y == '0)
                r = (WRAP != 0) ? {1'b1, Y_MAX} : {1'b0, y};
            else
                r = {1'b1, y - 1'b1};
        end
        return r;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk   (clk),
            .reset (reset),
            .raw   (~btn_n[i]),
            .level (pressed[i])
        );
    end

    assign single = (pressed != 4'b0000) && ((pressed & (pressed - 4'd1)) == 4'b0000);
    // held is one-hot, so equality also rejects a second button being added
    assign same   = (pressed == held);

    // debounced levels -> move decision
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            held      <= 4'b0000;
            delay_cnt <= '0;
            vld_p0    <= 1'b0;
            dir_p0    <= DIR_NONE;
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (single) begin
                        state     <= HOLD;
                        held      <= pressed;
                        delay_cnt <= DELAY_LOAD;
                        vld_p0    <= enable;
                        dir_p0    <= btn_to_dir(pressed);
                    end
                end
                HOLD, REPEAT: begin
                    if (!same) begin
                        state <= IDLE;
                    end else if (delay_cnt == '0) begin
                        state     <= REPEAT;
                        delay_cnt <= PERIOD_LOAD;
                        vld_p0    <= enable;
                        dir_p0    <= btn_to_dir(held);
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        nx = {1'b0, cur_x};
        ny = {1'b0, cur_y};
        case (dir_p0)
            DIR_LEFT:  nx = step_x(cur_x, 1'b0);
            DIR_RIGHT: nx = step_x(cur_x, 1'b1);
            DIR_UP:    ny = step_y(cur_y, 1'b0);
            DIR_DOWN:  ny = step_y(cur_y, 1'b1);
            default:   ;
        endcase
    end

    // move decision -> position register
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x      <= '0;
            cur_y      <= '0;
            move_pulse <= 1'b0;
            move_dir   <= DIR_NONE;
        end else begin
            move_pulse <= 1'b0;
            if (vld_p0 && (nx[XW] || ny[YW])) begin
                cur_x      <= nx[XW-1:0];
                cur_y      <= ny[YW-1:0];
                move_pulse <= 1'b1;
                move_dir   <= dir_p0;
            end
        end
    end

endmodule

// File: tb/tb_cursor_controller.sv
// Scoreboard bench for cursor_controller: expected moves (cycle, dir, x, y)
// are queued as stimulus is driven and matched against observed move pulses.
module tb_cursor_controller;
    import cursor_pkg::*;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] btn_n  = 4'hF;
    logic       enable = 1'b1;

    logic [2:0] cur_x, cur_y, cur_x_c, cur_y_c;
    logic       move_pulse, move_pulse_c;
    dir_e       move_dir, move_dir_c;

    typedef struct packed {
        int         cyc;
        logic [2:0] dir;
        logic [2:0] x;
        logic [2:0] y;
    } ev_t;

    ev_t obs_q[$];
    ev_t obs_c_q[$];
    ev_t exp_q[$];
    int  cyc   = 0;
    int  rd    = 0;
    int  total = 0;
    int  bad   = 0;

    cursor_controller #(
        .COLS(COLS), .ROWS(ROWS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .WRAP(1)
    ) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .enable(enable),
        .cur_x(cur_x), .cur_y(cur_y), .move_pulse(move_pulse), .move_dir(move_dir)
    );

    cursor_controller #(
        .COLS(COLS), .ROWS(ROWS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .WRAP(0)
    ) dut_c (
        .clk(clk), .reset(reset), .btn_n(btn_n), .enable(enable),
        .cur_x(cur_x_c), .cur_y(cur_y_c), .move_pulse(move_pulse_c), .move_dir(move_dir_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (move_pulse)
            obs_q.push_back('{cyc, 3'(move_dir), cur_x, cur_y});
        if (move_pulse_c)
            obs_c_q.push_back('{cyc, 3'(move_dir_c), cur_x_c, cur_y_c});
    end

    task automatic goto_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        btn_n  = 4'hF;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd = obs_q.size();
    endtask

    task automatic test_reset();
        do_reset();
        total += 8;
        if (cur_x !== 3'd0) begin bad++; $display("FAIL reset_x: got %0d required 0", cur_x); end
        if (cur_y !== 3'd0) begin bad++; $display("FAIL reset_y: got %0d required 0", cur_y); end
        if (move_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b required 0", move_pulse); end
        if (move_dir !== DIR_NONE) begin bad++; $display("FAIL reset_dir: got %0d required %0d", move_dir, DIR_NONE); end
        if (cur_x_c !== 3'd0) begin bad++; $display("FAIL reset_x_clamp: got %0d required 0", cur_x_c); end
        if (cur_y_c !== 3'd0) begin bad++; $display("FAIL reset_y_clamp: got %0d required 0", cur_y_c); end
        if (move_pulse_c !== 1'b0) begin bad++; $display("FAIL reset_pulse_clamp: got %b required 0", move_pulse_c); end
        if (move_dir_c !== DIR_NONE) begin bad++; $display("FAIL reset_dir_clamp: got %0d required %0d", move_dir_c, DIR_NONE); end
    endtask

    task automatic test_single_right();
        int  c;
        ev_t e;
        do_reset();
        c = cyc;
        btn_n = 4'b1110;
        exp_q.push_back('{c + 8, 3'(DIR_RIGHT), 3'd1, 3'd0});
        goto_cycle(c + 8);
        btn_n = 4'hF;
        goto_cycle(c + 30);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL single_right: pulse missing, required %p", e); end
            else begin
                if (obs_q[rd] !== e) begin bad++; $display("FAIL single_right: got %p required %p", obs_q[rd], e); end
                rd++;
            end
        end
        total++;
        if (obs_q.size() != rd) begin bad++; $display("FAIL single_right_count: pulses=%0d required=%0d", obs_q.size(), rd); end
        total++;
        if (cur_x !== 3'd1 || cur_y !== 3'd0) begin bad++; $display("FAIL single_right_pos: got %0d,%0d required 1,0", cur_x, cur_y); end
    endtask

    task automatic test_wrap_up();
        int  c;
        int  rc;
        ev_t e;
        do_reset();
        rc = obs_c_q.size();
        c = cyc;
        btn_n = 4'b0111;
        exp_q.push_back('{c + 8, 3'(DIR_UP), 3'd0, 3'd5});
        goto_cycle(c + 8);
        btn_n = 4'hF;
        goto_cycle(c + 30);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL wrap_up: pulse missing, required %p", e); end
            else begin
                if (obs_q[rd] !== e) begin bad++; $display("FAIL wrap_up: got %p required %p", obs_q[rd], e); end
                rd++;
            end
        end
        total++;
        if (obs_q.size() != rd) begin bad++; $display("FAIL wrap_up_count: pulses=%0d required=%0d", obs_q.size(), rd); end
        total++;
        if (obs_c_q.size() != rc) begin bad++; $display("FAIL clamp_up_pulse: pulses=%0d required=%0d", obs_c_q.size(), rc); end
        total++;
        if (cur_y_c !== 3'd0) begin bad++; $display("FAIL clamp_up_y: got %0d required 0", cur_y_c); end
    endtask

    task automatic test_bounce();
        int c;
        do_reset();
        c = cyc;
        for (int k = 0; k < 10; k++) begin
            btn_n = (k % 2 == 0) ? 4'b1110 : 4'b1111;
            goto_cycle(c + 2 * (k + 1));
        end
        btn_n = 4'hF;
        goto_cycle(c + 40);
        total++;
        if (obs_q.size() != rd) begin bad++; $display("FAIL bounce_count: pulses=%0d required=%0d", obs_q.size(), rd); end
        total++;
        if (cur_x !== 3'd0) begin bad++; $display("FAIL bounce_x: got %0d required 0", cur_x); end
    endtask

    task automatic test_hold_down();
        int  c;
        ev_t e;
        int  offs[7] = '{8, 18, 23, 28, 33, 38, 43};
        do_reset();
        c = cyc;
        btn_n = 4'b1101;
        for (int k = 0; k < 7; k++)
            exp_q.push_back('{c + offs[k], 3'(DIR_DOWN), 3'd0, 3'((k + 1) % ROWS)});
        goto_cycle(c + 40);
        btn_n = 4'hF;
        goto_cycle(c + 60);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL hold_down: pulse missing, required %p", e); end
            else begin
                if (obs_q[rd] !== e) begin bad++; $display("FAIL hold_down: got %p required %p", obs_q[rd], e); end
                rd++;
            end
        end
        total++;
        if (obs_q.size() != rd) begin bad++; $display("FAIL hold_down_count: pulses=%0d required=%0d", obs_q.size(), rd); end
        total++;
        if (cur_y !== 3'd1) begin bad++; $display("FAIL hold_down_y: got %0d required 1", cur_y); end
    endtask

    task automatic test_two_buttons();
        int  c;
        ev_t e;
        do_reset();
        c = cyc;
        btn_n = 4'b1011;
        exp_q.push_back('{c + 8, 3'(DIR_LEFT), 3'd7, 3'd0});
        goto_cycle(c + 6);
        btn_n = 4'b0011;
        goto_cycle(c + 30);
        btn_n = 4'b1011;
        exp_q.push_back('{c + 38, 3'(DIR_LEFT), 3'd6, 3'd0});
        goto_cycle(c + 40);
        btn_n = 4'hF;
        goto_cycle(c + 60);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL two_buttons: pulse missing, required %p", e); end
            else begin
                if (obs_q[rd] !== e) begin bad++; $display("FAIL two_buttons: got %p required %p", obs_q[rd], e); end
                rd++;
            end
        end
        total++;
        if (obs_q.size() != rd) begin bad++; $display("FAIL two_buttons_count: pulses=%0d required=%0d", obs_q.size(), rd); end
        total++;
        if (cur_x !== 3'd6) begin bad++; $display("FAIL two_buttons_x: got %0d required 6", cur_x); end
    endtask

    task automatic test_enable();
        int  c;
        ev_t e;
        do_reset();
        c = cyc;
        btn_n  = 4'b1110;
        enable = 1'b0;
        goto_cycle(c + 23);
        enable = 1'b1;
        exp_q.push_back('{c + 28, 3'(DIR_RIGHT), 3'd1, 3'd0});
        exp_q.push_back('{c + 33, 3'(DIR_RIGHT), 3'd2, 3'd0});
        exp_q.push_back('{c + 38, 3'(DIR_RIGHT), 3'd3, 3'd0});
        goto_cycle(c + 34);
        btn_n = 4'hF;
        goto_cycle(c + 60);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL enable_gate: pulse missing, required %p", e); end
            else begin
                if (obs_q[rd] !== e) begin bad++; $display("FAIL enable_gate: got %p required %p", obs_q[rd], e); end
                rd++;
            end
        end
        total++;
        if (obs_q.size() != rd) begin bad++; $display("FAIL enable_gate_count: pulses=%0d required=%0d", obs_q.size(), rd); end
    endtask

    task automatic test_reset_during_repeat();
        int  c;
        ev_t e;
        do_reset();
        c = cyc;
        btn_n = 4'b1101;
        exp_q.push_back('{c + 8, 3'(DIR_DOWN), 3'd0, 3'd1});
        exp_q.push_back('{c + 18, 3'(DIR_DOWN), 3'd0, 3'd2});
        goto_cycle(c + 20);
        reset = 1'b1;
        goto_cycle(c + 21);
        total += 2;
        if (cur_y !== 3'd0 || cur_x !== 3'd0) begin bad++; $display("FAIL midreset_pos: got %0d,%0d required 0,0", cur_x, cur_y); end
        if (move_pulse !== 1'b0) begin bad++; $display("FAIL midreset_pulse: got %b required 0", move_pulse); end
        reset = 1'b0;
        exp_q.push_back('{c + 29, 3'(DIR_DOWN), 3'd0, 3'd1});
        goto_cycle(c + 31);
        btn_n = 4'hF;
        goto_cycle(c + 50);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd >= obs_q.size()) begin bad++; $display("FAIL midreset_move: pulse missing, required %p", e); end
            else begin
                if (obs_q[rd] !== e) begin bad++; $display("FAIL midreset_move: got %p required %p", obs_q[rd], e); end
                rd++;
            end
        end
        total++;
        if (obs_q.size() != rd) begin bad++; $display("FAIL midreset_count: pulses=%0d required=%0d", obs_q.size(), rd); end
    endtask

    initial begin
        test_reset();
        test_single_right();
        test_wrap_up();
        test_bounce();
        test_hold_down();
        test_two_buttons();
        test_enable();
        test_reset_during_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cursor_controller.md
Name: cursor_controller

Overview:
- Moves the Buscaminas board cursor over a parametrised COLS x ROWS grid from four active-low push-buttons.
- Adds input synchronisation, per-button debounce, one move per press, hold-to-auto-repeat, and selectable wrap or clamp at the edges.
- Sits between the board pushbuttons and the board/VGA logic; `cur_x`/`cur_y` index the tile under the cursor.

Parameters:
- COLS, 8, grid columns (>=2)
- ROWS, 8, grid rows (>=2)
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required to accept a button level change (>=1)
- REPEAT_DELAY, 25000000, cycles a single button must be held after its first move before auto-repeat starts (>=1)
- REPEAT_PERIOD, 5000000, cycles between auto-repeat moves (>=1)
- WRAP, 1, 1 = wrap at edges, 0 = clamp at edges

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_n  in  4  raw buttons, active-low, asynchronous; [3]=up, [2]=left, [1]=down, [0]=right
- enable  in  1  1 = moves allowed; 0 = all moves suppressed, debounce keeps running
- cur_x  out  $clog2(COLS)  cursor column, 0 = leftmost
- cur_y  out  $clog2(ROWS)  cursor row, 0 = top
- move_pulse  out  1  one-cycle strobe in the cycle cur_x/cur_y take a new value
- move_dir  out  3  dir_e of the last accepted move; valid while move_pulse=1

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - cur_x=0, cur_y=0, move_pulse=0, move_dir=DIR_NONE.
  - Synchroniser flops, debounced levels, counters and FSM all clear; debounced levels clear to "released".
- Input path per button: invert, then 2-flop synchroniser, then debouncer.
- Debouncer: counter restarts whenever the synchronised level equals the debounced level. When it differs for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips on the next edge.
- Press condition: exactly one debounced button pressed (one-hot). Zero or several pressed = "no valid press".
- FSM states IDLE, HOLD, REPEAT:
  - IDLE: on a valid press, issue a move and go to HOLD; the delay counter loads REPEAT_DELAY-1.
  - HOLD: if the same single button is still pressed, count down; at 0, issue a move, go to REPEAT and load REPEAT_PERIOD-1. Any other condition (release, second button added, different button) returns to IDLE with no move. A new single button needs a fresh IDLE->HOLD pass, so the earliest next move is the cycle after IDLE.
  - REPEAT: same rules as HOLD, but every expiry issues a move and reloads REPEAT_PERIOD-1.
- Move issue: cur_x/cur_y update on the clock edge after the issuing decision. move_pulse and move_dir are registered and coincide with the new position.
- Latency from a clean raw press to the first move: 2 (synchroniser) + DEBOUNCE_CYCLES + 1 (FSM) + 1 (position register) cycles.
- Arithmetic: widths are $clog2(COLS) and $clog2(ROWS). No modulo operator; compare explicitly against 0 and COLS-1 / ROWS-1.
  - up: y==0 gives ROWS-1 (WRAP=1) or 0 (WRAP=0); otherwise y-1.
  - down: y==ROWS-1 gives 0 (WRAP=1) or hold (WRAP=0); otherwise y+1.
  - left/right: symmetric on x with COLS-1.
- Clamped move (WRAP=0 at an edge): position unchanged, move_pulse=0, the FSM still advances normally.
- Non-power-of-two COLS/ROWS: cur_x <= COLS-1 and cur_y <= ROWS-1 at all times.
- enable=0: issue points are consumed with no position change and no pulse; the FSM keeps tracking.
- Reset mid-hold: everything clears. A button still held after reset must re-debounce before the first move.

Decomposition:
- Package cursor_pkg:
  - typedef enum logic[2:0] dir_e {DIR_NONE, DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT}
  - button index constants BTN_UP=3, BTN_LEFT=2, BTN_DOWN=1, BTN_RIGHT=0
  - typedef enum state_e {IDLE, HOLD, REPEAT}
- Sub-module btn_debouncer (parameter DEBOUNCE_CYCLES; ports clk, reset, raw, level), holding the synchroniser plus counter; instantiated 4 times.

Test Plan (COLS=8, ROWS=6, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, WRAP=1 unless stated):
- Reset, then btn_n=4'b1110 held for 8 cycles and released -> exactly one move_pulse, dir=DIR_RIGHT, cur_x=1, cur_y=0, pulse 2+4+2 cycles after the press.
- Press up from reset -> cur_y=5 (wrap). With WRAP=0, same stimulus -> cur_y stays 0, no move_pulse.
- Right bounce: toggle btn_n[0] every 2 cycles for 20 cycles, then release -> no move, cur_x=0.
- Hold down for 40 cycles after debounce -> moves at issue offsets 0, 10, 15, 20, 25, 30, 35 -> 7 pulses, cur_y=(0+7) mod 6=1.
- Hold left, add up on cycle 5 of HOLD -> FSM returns to IDLE, no further moves while both are held. Release up -> left re-enters HOLD and moves once more.
- Reset asserted during REPEAT with down held -> cur_y=0 and move_pulse=0 on the next edge. After reset deasserts, the first move waits the full debounce latency.
